// File: rtl/display_scheduler.sv
// display_scheduler: selects the 8-digit frame shown by the 7-segment driver.
// Normal frames merge timer and score with leading-zero blanking and a
// low-time blink; a req/ack handshake overlays a timed message followed by
// a blank gap. Digit code 4'hF means blank.
module display_scheduler #(
  parameter int unsigned BLINK_DIV  = 250,
  parameter int unsigned MSG_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES = 50
) (
  input  logic        nclk,
  input  logic        rst_n,
  input  logic [15:0] time_bcd,
  input  logic [15:0] score_bcd,
  input  logic        low_time,
  input  logic        msg_req,
  input  logic [31:0] msg_data,
  output logic        msg_ack,
  output logic        busy,
  output logic [3:0]  display7,
  output logic [3:0]  display6,
  output logic [3:0]  display5,
  output logic [3:0]  display4,
  output logic [3:0]  display3,
  output logic [3:0]  display2,
  output logic [3:0]  display1,
  output logic [3:0]  display0
);

  localparam logic [15:0] BLINK_LAST = 16'(BLINK_DIV - 1);
  localparam logic [15:0] MSG_LAST   = 16'(MSG_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_MSG_SHOW = 2'd1,
    ST_MSG_GAP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] dur_cnt;
  logic [15:0] dur_next;
  logic        busy_next;
  logic        ack_next;
  logic        load_buf;
  logic [31:0] msg_buf;

  logic [15:0] blink_cnt;
  logic        blink_phase;

  logic [15:0] time_field;
  logic [31:0] frame_next;
  logic [31:0] frame;

  // Blank every digit that is zero along with all more significant digits;
  // the least significant digit of the field is always shown.
  function automatic logic [15:0] blank_lz(input logic [15:0] field);
    logic lead;
    blank_lz = field;
    lead     = 1'b1;
    for (int unsigned i = 3; i > 0; i--) begin
      lead = lead && (field[4*i +: 4] == 4'd0);
      if (lead) begin
        blank_lz[4*i +: 4] = 4'hF;
      end
    end
  endfunction

  // Free-running blink prescaler; phase toggles on each wrap.
  always_ff @(posedge nclk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 16'd1;
    end
  end

  // FSM state register together with its counter, flags and message buffer.
  always_ff @(posedge nclk) begin
    if (!rst_n) begin
      state   <= ST_NORMAL;
      dur_cnt <= '0;
      busy    <= 1'b0;
      msg_ack <= 1'b0;
      msg_buf <= '0;
    end else begin
      state   <= state_next;
      dur_cnt <= dur_next;
      busy    <= busy_next;
      msg_ack <= ack_next;
      if (load_buf) begin
        msg_buf <= msg_data;
      end
    end
  end

  // Next-state logic: accept a request in NORMAL, then time the show and gap.
  always_comb begin
    state_next = state;
    dur_next   = dur_cnt;
    busy_next  = busy;
    ack_next   = 1'b0;
    load_buf   = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (msg_req) begin
          load_buf   = 1'b1;
          ack_next   = 1'b1;
          busy_next  = 1'b1;
          dur_next   = '0;
          state_next = ST_MSG_SHOW;
        end
      end
      ST_MSG_SHOW: begin
        if (dur_cnt == MSG_LAST) begin
          dur_next   = '0;
          state_next = ST_MSG_GAP;
        end else begin
          dur_next   = dur_cnt + 16'd1;
        end
      end
      ST_MSG_GAP: begin
        if (dur_cnt == GAP_LAST) begin
          busy_next  = 1'b0;
          state_next = ST_NORMAL;
        end else begin
          dur_next   = dur_cnt + 16'd1;
        end
      end
      default: begin
        busy_next  = 1'b0;
        state_next = ST_NORMAL;
      end
    endcase
  end

  // Frame selection from the pre-edge state; time field blinks when low.
  always_comb begin
    time_field = blank_lz(time_bcd);
    if (low_time && blink_phase) begin
      time_field = '1;
    end
    case (state)
      ST_NORMAL:   frame_next = {time_field, blank_lz(score_bcd)};
      ST_MSG_SHOW: frame_next = msg_buf;
      ST_MSG_GAP:  frame_next = '1;
      default:     frame_next = '1;
    endcase
  end

  // Display register: one cycle behind state and inputs.
  always_ff @(posedge nclk) begin
    if (!rst_n) begin
      frame <= '1;
    end else begin
      frame <= frame_next;
    end
  end

  assign display7 = frame[31:28];
  assign display6 = frame[27:24];
  assign display5 = frame[23:20];
  assign display4 = frame[19:16];
  assign display3 = frame[15:12];
  assign display2 = frame[11:8];
  assign display1 = frame[7:4];
  assign display0 = frame[3:0];

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with a scoreboard of expected frames.
module tb_display_scheduler;

  logic        nclk;
  logic        rst_n;
  logic [15:0] time_bcd;
  logic [15:0] score_bcd;
  logic        low_time;
  logic        msg_req;
  logic [31:0] msg_data;
  logic        msg_ack;
  logic        busy;
  logic [3:0]  display7, display6, display5, display4;
  logic [3:0]  display3, display2, display1, display0;

  display_scheduler #(
    .BLINK_DIV (4),
    .MSG_CYCLES(4),
    .GAP_CYCLES(2)
  ) dut (
    .nclk     (nclk),
    .rst_n    (rst_n),
    .time_bcd (time_bcd),
    .score_bcd(score_bcd),
    .low_time (low_time),
    .msg_req  (msg_req),
    .msg_data (msg_data),
    .msg_ack  (msg_ack),
    .busy     (busy),
    .display7 (display7),
    .display6 (display6),
    .display5 (display5),
    .display4 (display4),
    .display3 (display3),
    .display2 (display2),
    .display1 (display1),
    .display0 (display0)
  );

  initial nclk = 1'b0;
  always #5 nclk = ~nclk;

  typedef struct {
    string       tag;
    logic [31:0] disp;
    logic        ack;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   edges  = 0;   // active-reset-free edges since last reset release

  localparam logic [31:0] ALL_F = 32'hFFFF_FFFF;

  // Expected field: digits above the highest nonzero digit are blank.
  function automatic logic [15:0] exp_field(input logic [15:0] f);
    int hp;
    hp = 0;
    for (int j = 0; j < 4; j++) begin
      if (f[4*j +: 4] != 4'd0) hp = j;
    end
    exp_field = f;
    for (int j = 0; j < 4; j++) begin
      if (j > hp) exp_field[4*j +: 4] = 4'hF;
    end
  endfunction

  function automatic logic [31:0] exp_normal(input logic [15:0] t, input logic [15:0] s,
                                             input logic low, input logic phase);
    logic [15:0] tf;
    tf = (low && phase) ? 16'hFFFF : exp_field(t);
    exp_normal = {tf, exp_field(s)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Push the expectation for the next edge, clock it, then pop and compare.
  task automatic tick(input string tag, input logic [31:0] d, input logic a, input logic b);
    exp_t e;
    e.tag = tag; e.disp = d; e.ack = a; e.busy = b;
    sb.push_back(e);
    @(posedge nclk);
    edges++;
    #1;
    e = sb.pop_front();
    check({e.tag, ".display"},
          {display7, display6, display5, display4, display3, display2, display1, display0},
          e.disp);
    check({e.tag, ".msg_ack"}, {31'd0, msg_ack}, {31'd0, e.ack});
    check({e.tag, ".busy"}, {31'd0, busy}, {31'd0, e.busy});
  endtask

  // Normal frame expected for current inputs; blink phase before edge k+1 is (k/4)%2.
  task automatic norm(input string tag, input logic a, input logic b);
    logic phase;
    phase = ((edges / 4) % 2) == 1;
    tick(tag, exp_normal(time_bcd, score_bcd, low_time, phase), a, b);
  endtask

  initial begin
    rst_n     = 1'b0;
    time_bcd  = '0;
    score_bcd = '0;
    low_time  = 1'b0;
    msg_req   = 1'b0;
    msg_data  = '0;

    // Reset held for two edges
    tick("reset0", ALL_F, 1'b0, 1'b0);
    tick("reset1", ALL_F, 1'b0, 1'b0);
    rst_n = 1'b1;
    edges = 0;

    // Leading-zero blanking
    time_bcd = 16'h0030; score_bcd = 16'h0042;
    tick("blank_30_42", 32'hFF30_FF42, 1'b0, 1'b0);
    tick("blank_30_42b", 32'hFF30_FF42, 1'b0, 1'b0);
    time_bcd = 16'h0000; score_bcd = 16'h0000;
    tick("blank_zero", 32'hFFF0_FFF0, 1'b0, 1'b0);
    time_bcd = 16'h1234; score_bcd = 16'h0905;
    tick("blank_1234_0905", 32'h1234_F905, 1'b0, 1'b0);
    time_bcd = 16'hA000; score_bcd = 16'h0100;
    tick("nonbcd_pass", 32'hA000_F100, 1'b0, 1'b0);

    // Blink: time field toggles every 4 cycles, score steady
    low_time = 1'b1; time_bcd = 16'h0009; score_bcd = 16'h0042;
    for (int i = 0; i < 12; i++) norm($sformatf("blink%0d", i), 1'b0, 1'b0);
    low_time = 1'b0;

    // Single message, request dropped after ack; msg_data changes afterwards
    msg_req = 1'b1; msg_data = 32'h1234_5678;
    norm("msg_accept", 1'b1, 1'b1);
    msg_req = 1'b0; msg_data = 32'hDEAD_BEEF;
    for (int i = 1; i <= 4; i++) tick($sformatf("msg_show%0d", i), 32'h1234_5678, 1'b0, 1'b1);
    tick("msg_gap5", ALL_F, 1'b0, 1'b1);
    tick("msg_gap6", ALL_F, 1'b0, 1'b0);
    norm("msg_back7", 1'b0, 1'b0);
    norm("msg_idle8", 1'b0, 1'b0);

    // Held request: one ack per message cycle, re-accepted one cycle after busy falls
    msg_req = 1'b1; msg_data = 32'h0F0A_0000;
    norm("held_accept", 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) tick($sformatf("held_show%0d", i), 32'h0F0A_0000, 1'b0, 1'b1);
    tick("held_gap5", ALL_F, 1'b0, 1'b1);
    tick("held_gap6", ALL_F, 1'b0, 1'b0);
    msg_data = 32'h9876_5432;
    norm("held_reaccept7", 1'b1, 1'b1);
    msg_req = 1'b0;
    tick("held2_show1", 32'h9876_5432, 1'b0, 1'b1);
    tick("held2_show2", 32'h9876_5432, 1'b0, 1'b1);

    // Reset during MSG_SHOW aborts the message
    rst_n = 1'b0;
    tick("midreset", ALL_F, 1'b0, 1'b0);
    rst_n = 1'b1;
    edges = 0;
    norm("after_reset", 1'b0, 1'b0);
    norm("after_reset2", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
